opcode_decode_stage: RTL and testbench
======================================

Name: opcode_decode_stage

Overview:
- Registered front end that feeds the control ROM.
- Accepts 32-bit instructions over a valid/ready handshake and extracts the 6-bit opcode.
- Presents a 64-bit one-hot opcode vector (the control ROM's decoder input) together with the original instruction, behind a 2-entry skid buffer.
- Flags illegal opcodes and keeps a saturating illegal-opcode count for debug.

Parameters:
- INSTR_W, 32, instruction width.
- OPC_LSB, 26, bit position of the opcode field LSB in the instruction (field is OPC_LSB+5 : OPC_LSB).
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  INSTR_W  instruction word.
- out_valid  out  1  out_* fields hold a decoded entry.
- out_ready  in  1  downstream (control ROM / datapath) accepts.
- out_onehot  out  64  one-hot opcode vector; bit index = opcode value.
- out_instr  out  INSTR_W  instruction associated with out_onehot.
- out_illegal  out  1  entry's opcode is not in the legal set.
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes accepted.

Behaviour:
- Reset (rst_n low, async): out_valid=0, in_ready=0 while asserted, then 1 on the first clk after release.
  - out_onehot=0, out_instr=0, out_illegal=0, illegal_cnt=0, both buffer slots empty.
- Reset mid-transfer discards all entries; no partial output survives.
- Accept: handshake in_valid & in_ready at a clk edge.
- Deliver: handshake out_valid & out_ready at a clk edge.
- Latency: an accepted instruction appears on out_* the next cycle when the main slot is empty or draining.
- Structure: main output register plus one skid slot.
  - in_ready = !skid_full, and is a registered signal.
  - If the main slot is full, not delivered, and an accept occurs, the instruction goes to the skid slot.
  - On the next delivery the skid slot moves into the main slot.
  - Simultaneous accept and deliver with an empty skid slot: the new entry goes straight into the main slot, and out_valid stays 1.
- FSM states:
  - EMPTY (out_valid=0)
  - ONE (main full, skid empty)
  - TWO (both full, in_ready=0)
- FSM transitions:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without deliver.
  - ONE → EMPTY on deliver without accept.
  - ONE → ONE on accept with deliver.
  - TWO → ONE on deliver (no accept is possible in TWO).
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Holding: out_* are stable while out_valid=1 and out_ready=0.
- Decode, performed at accept time and stored with the entry: opc = in_instr[OPC_LSB+5:OPC_LSB].
  - Legal set: OP_ADD=62, OP_BEQ=55, OP_LW=14, OP_SW=10, OP_NOR=6.
  - Legal opcode: out_onehot = 1<<opc, out_illegal=0.
  - Illegal opcode: out_onehot = 0, out_illegal=1, and the entry is still delivered.
- illegal_cnt: increments by 1 on each accepted illegal instruction; saturates at 2^CNT_W-1, with no wrap. flush does not clear it.
- flush has priority over accept and deliver in the same cycle.
  - State goes to EMPTY and out_valid=0 next cycle.
  - An instruction presented in the flush cycle is not accepted: in_ready is forced to 0 combinationally during flush.
  - illegal_cnt is not incremented for it.
- Unknown/X on in_instr while in_valid=0 must not affect state.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants OP_ADD, OP_BEQ, OP_LW, OP_SW, OP_NOR;
  - OPC_W=6 and ONEHOT_W=64;
  - LEGAL_MASK, a 64-bit constant with the five legal bits set.
- One sub-module, opcode_onehot_dec: purely combinational.
  - Inputs: opc[5:0].
  - Outputs: onehot[63:0] (masked by LEGAL_MASK) and illegal.
  - It is instantiated once, at the input side.
- Handshake/skid logic and counter live in the top.

Test Plan:
1. Single ADD: in_instr=32'hF800_0000 (opc 62), out_ready=1.
   - Next cycle out_valid=1, out_onehot=64'h4000_0000_0000_0000, out_illegal=0.
2. Back-to-back NOR, LW, SW, BEQ with out_ready=1 every cycle.
   - Outputs in order on consecutive cycles: onehots 64'h40, 64'h4000, 64'h400, 64'h0080_0000_0000_0000.
   - in_ready stays 1 throughout.
3. Backpressure: out_ready=0, then offer ADD, LW, BEQ.
   - ADD and LW are accepted; in_ready=0 after the second accept; BEQ is held.
   - Raise out_ready: the three are delivered in order (ADD, LW, BEQ), with no loss.
4. Illegal opcode 0 offered 300 times with CNT_W=8.
   - Each entry is delivered with out_onehot=0 and out_illegal=1.
   - illegal_cnt ends at 255.
5. Flush while in state TWO, with in_valid=1 in the same cycle.
   - Next cycle out_valid=0, in_ready=1; the flush-cycle instruction does not appear at the output.
6. Assert rst_n=0 asynchronously mid-stream (no clk edge).
   - All outputs go to reset values immediately; illegal_cnt=0.
   - After release, the first accepted instruction decodes correctly.

Source files
------------

// File: rtl/opcode_decode_stage_pkg.sv
// cpu_ctrl_pkg: opcode constants, legal-opcode mask and skid-buffer state type
// shared by the decode front end.
package cpu_ctrl_pkg;
  localparam int OPC_W = 6;
  localparam int ONEHOT_W = 64;
  localparam logic [OPC_W-1:0] OP_ADD = 6'd62;
  localparam logic [OPC_W-1:0] OP_BEQ = 6'd55;
  localparam logic [OPC_W-1:0] OP_LW = 6'd14;
  localparam logic [OPC_W-1:0] OP_SW = 6'd10;
  localparam logic [OPC_W-1:0] OP_NOR = 6'd6;
  localparam logic [ONEHOT_W-1:0] LEGAL_MASK = (ONEHOT_W'(1) << OP_ADD) | (ONEHOT_W'(1) << OP_BEQ) |
    (ONEHOT_W'(1) << OP_LW) | (ONEHOT_W'(1) << OP_SW) | (ONEHOT_W'(1) << OP_NOR);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skidStateT;
endpackage

// File: rtl/opcode_onehot_dec.sv
// opcode_onehot_dec: opcode to one-hot control-ROM select; opcodes outside the
// legal set produce an all-zero vector and raise illegal.
module opcode_onehot_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]    opc,
  output logic [ONEHOT_W-1:0] onehot,
  output logic                illegal
);
  assign onehot = (ONEHOT_W'(1) << opc) & LEGAL_MASK;
  assign illegal = ~|onehot;
endmodule

// File: rtl/opcode_decode_stage.sv
// opcode_decode_stage: registered decode front end with a 2-entry skid buffer
// and a saturating illegal-opcode counter.
module opcode_decode_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int OPC_LSB = 26,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic [INSTR_W-1:0]  out_instr,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    illegal_cnt
);
  skidStateT state;
  logic inReadyReg, accept, deliver, decIllegal, skidIllegal;
  logic [ONEHOT_W-1:0] decOnehot, skidOnehot;
  logic [INSTR_W-1:0] skidInstr;
  assign in_ready = inReadyReg & ~flush;
  assign accept = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  opcode_onehot_dec uDec (
    .opc(in_instr[OPC_LSB +: OPC_W]),
    .onehot(decOnehot),
    .illegal(decIllegal)
  );
  // Decode happens once at accept; the result travels with the entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      inReadyReg <= 1'b0;
      out_valid <= 1'b0;
      out_onehot <= '0;
      out_instr <= '0;
      out_illegal <= 1'b0;
      skidOnehot <= '0;
      skidInstr <= '0;
      skidIllegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      inReadyReg <= 1'b1;
      if (accept && decIllegal && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
        out_valid <= 1'b0;
      end else
        case (state)
          EMPTY:
            if (accept) begin
              out_onehot <= decOnehot;
              out_instr <= in_instr;
              out_illegal <= decIllegal;
              out_valid <= 1'b1;
              state <= ONE;
            end
          ONE:
            if (accept && !deliver) begin
              skidOnehot <= decOnehot;
              skidInstr <= in_instr;
              skidIllegal <= decIllegal;
              inReadyReg <= 1'b0;
              state <= TWO;
            end else if (accept) begin
              out_onehot <= decOnehot;
              out_instr <= in_instr;
              out_illegal <= decIllegal;
            end else if (deliver) begin
              out_valid <= 1'b0;
              state <= EMPTY;
            end
          TWO:
            if (deliver) begin
              out_onehot <= skidOnehot;
              out_instr <= skidInstr;
              out_illegal <= skidIllegal;
              state <= ONE;
            end else
              inReadyReg <= 1'b0;
          default: state <= EMPTY;
        endcase
    end
endmodule

// File: tb/tb_opcode_decode_stage.sv
// tb_opcode_decode_stage: directed and randomized checks of the decode stage
// against a queue-based FIFO model of the buffered entries.
module tb_opcode_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid, out_illegal;
  logic [63:0] out_onehot;
  logic [31:0] out_instr;
  logic [7:0] illegal_cnt;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  int cnt = 0;
  logic rdy = 1'b0;
  logic [5:0] legalOps[5] = '{6'd62, 6'd55, 6'd14, 6'd10, 6'd6};

  opcode_decode_stage #(.INSTR_W(32), .OPC_LSB(26), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_instr(out_instr), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] expOnehot(input logic [31:0] ins);
    int o = int'(ins[31:26]);
    return (o == 62 || o == 55 || o == 14 || o == 10 || o == 6) ? (64'd1 << o) : 64'd0;
  endfunction

  function automatic logic [31:0] mkInstr();
    logic [5:0] o = $urandom_range(0, 1) == 1 ? legalOps[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
    return {o, 26'($urandom)};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies inputs, lets one edge pass, then advances the model by the handshakes it implies.
  task automatic step(input logic v, input logic [31:0] ins, input logic r, input logic f);
    logic acc, del, rstAtEdge;
    in_valid = v;
    in_instr = ins;
    out_ready = r;
    flush = f;
    @(posedge clk);
    rstAtEdge = rst_n;
    acc = rst_n && v && rdy && !f;
    del = rst_n && !f && q.size() > 0 && r;
    #1;
    if (!rstAtEdge) begin
      q.delete();
      cnt = 0;
    end else if (f) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) begin
        q.push_back(ins);
        if (expOnehot(ins) == 64'd0 && cnt < 255) cnt++;
      end
    end
    rdy = rstAtEdge && q.size() < 2;
  endtask

  always @(negedge clk) begin
    cmp("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    cmp("in_ready", {63'd0, in_ready}, {63'd0, rdy && !flush});
    cmp("illegal_cnt", {56'd0, illegal_cnt}, 64'(cnt));
    if (q.size() > 0) begin
      cmp("out_instr", {32'd0, out_instr}, {32'd0, q[0]});
      cmp("out_onehot", out_onehot, expOnehot(q[0]));
      cmp("out_illegal", {63'd0, out_illegal}, {63'd0, expOnehot(q[0]) == 64'd0});
    end
  end

  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    cmp("rst out_valid", {63'd0, out_valid}, 64'd0);
    cmp("rst in_ready", {63'd0, in_ready}, 64'd0);
    cmp("rst onehot", out_onehot, 64'd0);
    cmp("rst cnt", {56'd0, illegal_cnt}, 64'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    cmp("post-rst in_ready", {63'd0, in_ready}, 64'd1);
    step(1, 32'hF800_0000, 1, 0);
    cmp("add valid", {63'd0, out_valid}, 64'd1);
    cmp("add onehot", out_onehot, 64'h4000_0000_0000_0000);
    cmp("add illegal", {63'd0, out_illegal}, 64'd0);
    step(1, {6'd6, 26'h12345}, 1, 0);
    cmp("nor onehot", out_onehot, 64'h40);
    step(1, {6'd14, 26'h0ABCD}, 1, 0);
    cmp("lw onehot", out_onehot, 64'h4000);
    cmp("b2b in_ready", {63'd0, in_ready}, 64'd1);
    step(1, {6'd10, 26'h3}, 1, 0);
    cmp("sw onehot", out_onehot, 64'h400);
    step(1, {6'd55, 26'h7}, 1, 0);
    cmp("beq onehot", out_onehot, 64'h0080_0000_0000_0000);
    step(0, 0, 1, 0);
    step(1, {6'd62, 26'h1}, 0, 0);
    step(1, {6'd14, 26'h2}, 0, 0);
    cmp("bp in_ready", {63'd0, in_ready}, 64'd0);
    step(1, {6'd55, 26'h3}, 0, 0);
    cmp("bp hold", out_onehot, 64'h4000_0000_0000_0000);
    step(1, {6'd55, 26'h3}, 1, 0);
    cmp("bp lw", out_onehot, 64'h4000);
    step(1, {6'd55, 26'h3}, 1, 0);
    cmp("bp beq", out_onehot, 64'h0080_0000_0000_0000);
    step(0, 0, 1, 0);
    cmp("bp drained", {63'd0, out_valid}, 64'd0);
    step(1, {6'd62, 26'h4}, 0, 0);
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    cmp("flush forces in_ready", {63'd0, in_ready}, 64'd0);
    step(1, {6'd10, 26'h5}, 0, 1);
    step(1, {6'd62, 26'h6}, 0, 0);
    step(1, {6'd14, 26'h7}, 0, 0);
    step(1, {6'd10, 26'h8}, 0, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    cmp("flush valid", {63'd0, out_valid}, 64'd0);
    cmp("flush in_ready", {63'd0, in_ready}, 64'd1);
    step(0, 0, 1, 0);
    cmp("flush no sw", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), mkInstr(), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, {6'd0, 26'($urandom)}, 1, 0);
    cmp("ill onehot", out_onehot, 64'd0);
    cmp("ill flag", {63'd0, out_illegal}, 64'd1);
    step(0, 0, 1, 0);
    cmp("cnt saturated", {56'd0, illegal_cnt}, 64'd255);
    step(1, {6'd62, 26'h9}, 0, 0);
    step(1, {6'd55, 26'hA}, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst valid", {63'd0, out_valid}, 64'd0);
    cmp("arst in_ready", {63'd0, in_ready}, 64'd0);
    cmp("arst onehot", out_onehot, 64'd0);
    cmp("arst instr", {32'd0, out_instr}, 64'd0);
    cmp("arst illegal", {63'd0, out_illegal}, 64'd0);
    cmp("arst cnt", {56'd0, illegal_cnt}, 64'd0);
    q.delete();
    cnt = 0;
    rdy = 1'b0;
    step(1, {6'd14, 26'hB}, 1, 0);
    step(0, 0, 1, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    step(1, {6'd10, 26'hC}, 1, 0);
    cmp("post-arst onehot", out_onehot, 64'h400);
    cmp("post-arst instr", {32'd0, out_instr}, {32'd0, 6'd10, 26'hC});
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), mkInstr(), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
